alu_mdu: RTL and testbench

//  Parametrised multi-cycle execute unit: full base integer ALU plus RV32M-style multiply/divide.

---
 rtl/alu_mdu.sv | 188 ++++++++++++++++++
 tb/tb_alu_mdu.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_mdu.sv
// rtl/alu_mdu.sv - single-cycle ALU plus iterative multiply/divide execute unit
// Divider (DIV/DIVU/REM/REMU) is built only when ALU_MDU_DIV_EN is defined.
module alu_mdu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_zero,
    output logic            out_illegal
);
    localparam int SHW = $clog2(XLEN);
    localparam logic [SHW-1:0] LAST = SHW'(XLEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [SHW-1:0]      cnt_q, cnt_d;
    logic [2:0]          op_q, op_d;
    logic                sa_q, sa_d, sb_q, sb_d;
    logic [XLEN-1:0]     b_q, b_d;
    logic [2*XLEN-1:0]   p_q, p_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic                zero_q, zero_d, illegal_q, illegal_d;

    logic                base_legal, m_legal, a_signed, b_signed, sa_in, sb_in;
    logic [SHW-1:0]      shamt;
    logic [XLEN-1:0]     alu, a_mag, b_mag, base_res, fin;
    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   it_next, prod;

    always_comb begin
        base_legal = 1'b0;
        case (in_op[3:0])
            4'b0000, 4'b1000, 4'b0111, 4'b0110, 4'b0100,
            4'b0001, 4'b0101, 4'b1101, 4'b0010, 4'b0011: base_legal = !in_op[4];
            default: base_legal = 1'b0;
        endcase
`ifdef ALU_MDU_DIV_EN
        m_legal = in_op[4] & !in_op[3];
`else
        m_legal = in_op[4] & !in_op[3] & !in_op[2];
`endif
    end

    always_comb begin
        shamt = in_b[SHW-1:0];
        case (in_op[3:0])
            4'b0000: alu = in_a + in_b;
            4'b1000: alu = in_a - in_b;
            4'b0111: alu = in_a & in_b;
            4'b0110: alu = in_a | in_b;
            4'b0100: alu = in_a ^ in_b;
            4'b0001: alu = in_a << shamt;
            4'b0101: alu = in_a >> shamt;
            4'b1101: alu = XLEN'($signed(in_a) >>> shamt);
            4'b0010: alu = {{(XLEN-1){1'b0}}, $signed(in_a) < $signed(in_b)};
            4'b0011: alu = {{(XLEN-1){1'b0}}, in_a < in_b};
            default: alu = '0;
        endcase
        base_res = base_legal ? alu : '0;
    end

    // Operands go through the datapath as magnitudes; signs are reapplied on DONE entry.
    always_comb begin
        a_signed = in_op[2] ? !in_op[0] : (in_op[1:0] == 2'b01 || in_op[1:0] == 2'b10);
        b_signed = in_op[2] ? !in_op[0] : (in_op[1:0] == 2'b01);
        sa_in    = in_a[XLEN-1] & a_signed;
        sb_in    = in_b[XLEN-1] & b_signed;
        a_mag    = sa_in ? -in_a : in_a;
        b_mag    = sb_in ? -in_b : in_b;
    end

    // p_q holds {accumulator, multiplier} for multiply and {remainder, quotient} for divide.
    always_comb begin
        mul_sum = {1'b0, p_q[2*XLEN-1:XLEN]} + (p_q[0] ? {1'b0, b_q} : '0);
        it_next = {mul_sum, p_q[XLEN-1:1]};
        prod    = (sa_q ^ sb_q) ? -it_next : it_next;
        fin     = op_q[2] ? '0 : ((op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
`ifdef ALU_MDU_DIV_EN
        if (op_q[2]) begin
            logic [XLEN:0]   div_shift, div_diff;
            logic [XLEN-1:0] q_raw, r_raw;
            div_shift = {p_q[2*XLEN-1:XLEN], p_q[XLEN-1]};
            div_diff  = div_shift - {1'b0, b_q};
            it_next   = div_diff[XLEN] ? {div_shift[XLEN-1:0], p_q[XLEN-2:0], 1'b0}
                                       : {div_diff[XLEN-1:0], p_q[XLEN-2:0], 1'b1};
            q_raw     = it_next[XLEN-1:0];
            r_raw     = it_next[2*XLEN-1:XLEN];
            if (op_q[1])
                fin = sa_q ? -r_raw : r_raw;
            else if (b_q == '0)
                fin = '1;
            else
                fin = (sa_q ^ sb_q) ? -q_raw : q_raw;
        end
`endif
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        sa_d      = sa_q;
        sb_d      = sb_q;
        b_d       = b_q;
        p_d       = p_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: if (in_valid) begin
                    op_d  = in_op[2:0];
                    sa_d  = sa_in;
                    sb_d  = sb_in;
                    b_d   = b_mag;
                    p_d   = {{XLEN{1'b0}}, a_mag};
                    cnt_d = '0;
                    if (m_legal) begin
                        state_d = S_BUSY;
                    end else begin
                        state_d   = S_DONE;
                        result_d  = base_res;
                        zero_d    = (base_res == '0);
                        illegal_d = !base_legal;
                    end
                end
                S_BUSY: begin
                    p_d   = it_next;
                    cnt_d = cnt_q + SHW'(1);
                    if (cnt_q == LAST) begin
                        state_d   = S_DONE;
                        cnt_d     = '0;
                        result_d  = fin;
                        zero_d    = (fin == '0);
                        illegal_d = 1'b0;
                    end
                end
                S_DONE: if (out_ready) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            sa_q      <= 1'b0;
            sb_q      <= 1'b0;
            b_q       <= '0;
            p_q       <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            sa_q      <= sa_d;
            sb_q      <= sb_d;
            b_q       <= b_d;
            p_q       <= p_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign out_result  = result_q;
    assign out_zero    = zero_q;
    assign out_illegal = illegal_q;
endmodule

// File: tb/tb_alu_mdu.sv
// tb/tb_alu_mdu.sv - self-checking bench for alu_mdu against an arithmetic reference model
module tb_alu_mdu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_op = '0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_illegal;

    int pass_cnt = 0;
    int tot_cnt  = 0;
    int fail_cnt = 0;
    logic [31:0] last_res;

    alu_mdu #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_zero(out_zero), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tot_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ill, output int lat);
        int sa, sb, q;
        longint p;
        logic [63:0] u;
        sa = a;
        sb = b;
        r = '0;
        ill = 1'b0;
        case (op)
            5'b00000: r = a + b;
            5'b01000: r = a - b;
            5'b00111: r = a & b;
            5'b00110: r = a | b;
            5'b00100: r = a ^ b;
            5'b00001: r = a << b[4:0];
            5'b00101: r = a >> b[4:0];
            5'b01101: r = sa >>> b[4:0];
            5'b00010: r = (sa < sb) ? 32'd1 : 32'd0;
            5'b00011: r = (a < b) ? 32'd1 : 32'd0;
            5'b10000: begin u = {32'b0, a} * {32'b0, b}; r = u[31:0]; end
            5'b10001: begin p = longint'(sa) * longint'(sb); r = p[63:32]; end
            5'b10010: begin p = longint'(sa) * longint'({32'b0, b}); r = p[63:32]; end
            5'b10011: begin u = {32'b0, a} * {32'b0, b}; r = u[63:32]; end
`ifdef ALU_MDU_DIV_EN
            5'b10100: begin
                if (b == 0) r = '1;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = a;
                else begin q = sa / sb; r = q; end
            end
            5'b10101: begin if (b == 0) r = '1; else r = a / b; end
            5'b10110: begin
                if (b == 0) r = a;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = '0;
                else begin q = sa % sb; r = q; end
            end
            5'b10111: begin if (b == 0) r = a; else r = a % b; end
`endif
            default: ill = 1'b1;
        endcase
        lat = (op[4] && !ill) ? 33 : 1;
    endfunction

    // Called at #1 after a rising edge with the unit idle.
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [31:0] er;
        logic eill;
        int elat, lat;
        logic busy_rdy;
        model(op, a, b, er, eill, elat);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
        @(posedge clk); #1;
        in_valid = 1'b0; in_op = 5'($urandom); in_a = $urandom; in_b = $urandom;
        lat = 1;
        busy_rdy = 1'b0;
        while (!out_valid && lat < 100) begin
            if (in_ready) busy_rdy = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, elat);
        check("result", out_result, er);
        check("zero", {31'b0, out_zero}, {31'b0, er == 0});
        check("illegal", {31'b0, out_illegal}, {31'b0, eill});
        check("ready_while_busy", {31'b0, busy_rdy}, 32'd0);
        last_res = out_result;
        repeat (hold) begin
            @(posedge clk); #1;
            check("hold_valid", {31'b0, out_valid}, 32'd1);
            check("hold_result", out_result, er);
        end
        out_ready = 1'b1; in_valid = 1'b1; in_op = 5'b00000;
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        check("release_no_accept", {30'b0, out_valid, in_ready}, 32'd1);
    endtask

    initial begin
        logic [4:0]  ops[18] = '{5'b00000, 5'b01000, 5'b00111, 5'b00110, 5'b00100, 5'b00001,
                                 5'b00101, 5'b01101, 5'b00010, 5'b00011, 5'b10000, 5'b10001,
                                 5'b10010, 5'b10011, 5'b10100, 5'b10101, 5'b10110, 5'b10111};
        logic [31:0] corners[5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
        logic [31:0] prev, ra, rb;
        logic [4:0]  rop;
        logic        seen;

        #12;
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_outs", {29'b0, out_valid, out_zero, out_illegal}, 32'd0);
        check("rst_result", out_result, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(5'b00000, 32'h7FFFFFFF, 32'h1, 0);
        check("add_lit", last_res, 32'h80000000);
        run_op(5'b01000, 32'd5, 32'd5, 0);
        check("sub_lit", last_res, 32'h0);
        run_op(5'b01101, 32'h80000000, 32'h21, 0);
        check("sra_lit", last_res, 32'hC0000000);
        run_op(5'b10011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5);
        check("mulhu_lit", last_res, 32'hFFFFFFFE);
        run_op(5'b10100, 32'h80000000, 32'hFFFFFFFF, 0);
        run_op(5'b10110, 32'd7, 32'd0, 0);
        run_op(5'b10101, 32'd7, 32'd0, 5);
`ifdef ALU_MDU_DIV_EN
        check("divu_by0_lit", last_res, 32'hFFFFFFFF);
`else
        check("divu_disabled_lit", last_res, 32'h0);
`endif
        run_op(5'b11000, 32'd3, 32'd4, 0);

        for (int i = 0; i < 40; i++) begin
            rop = ($urandom_range(0, 9) < 8) ? ops[$urandom_range(0, 17)] : 5'($urandom);
            ra  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
            run_op(rop, ra, rb, $urandom_range(0, 2));
        end

        flush = 1'b1; in_valid = 1'b1; in_op = 5'b00000; in_a = 32'd9; in_b = 32'd9;
        prev = out_result;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush_idle_no_accept", {30'b0, out_valid, in_ready}, 32'd1);
        check("flush_idle_result", out_result, prev);

        in_valid = 1'b1; in_op = 5'b10001; in_a = 32'h12345678; in_b = 32'h9ABCDEF0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy_state", {30'b0, out_valid, in_ready}, 32'd1);
        check("flush_busy_result", out_result, prev);
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
        check("flush_no_stale", {31'b0, seen}, 32'd0);
        run_op(5'b10000, 32'hDEADBEEF, 32'h00C0FFEE, 1);

        in_valid = 1'b1; in_op = 5'b10011; in_a = 32'hCAFEF00D; in_b = 32'h13572468;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (20) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        check("arst_state", {30'b0, out_valid, in_ready}, 32'd1);
        check("arst_result", out_result, 32'd0);
        check("arst_flags", {30'b0, out_zero, out_illegal}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
        check("arst_no_stale", {31'b0, seen}, 32'd0);
        run_op(5'b00010, 32'hFFFFFFFE, 32'd1, 0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
